// File: rtl/mat_pkg.sv
// Shared types and helpers for the matrix streaming stages.
// idx_w gives the index width used for a dimension of n entries (never below 1 bit).
package mat_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} mat_stream_state_t;

  localparam int DATA_W = 32;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Two-level wrapping (row, col) counter that walks a SIZE_A x SIZE_B matrix.
// It steps in row-major or column-major order and flags the line and frame ends.
module mat_index_counter
  import mat_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  localparam int IW_A = idx_w(SIZE_A),
  localparam int IW_B = idx_w(SIZE_B)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  input  logic            col_major,
  output logic [IW_A-1:0] row,
  output logic [IW_B-1:0] col,
  output logic            last_col,
  output logic            last
);

  localparam logic [IW_A-1:0] ROW_MAX = IW_A'(SIZE_A - 1);
  localparam logic [IW_B-1:0] COL_MAX = IW_B'(SIZE_B - 1);

  logic [IW_A-1:0] row_q, row_d;
  logic [IW_B-1:0] col_q, col_d;
  logic            row_at_max;
  logic            col_at_max;

  assign row_at_max = (row_q == ROW_MAX);
  assign col_at_max = (col_q == COL_MAX);

  // The fast index wraps exactly at its maximum and carries into the slow one.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (!col_major) begin
        col_d = col_at_max ? '0 : col_q + 1'b1;
        if (col_at_max) begin
          row_d = row_at_max ? '0 : row_q + 1'b1;
        end
      end else begin
        row_d = row_at_max ? '0 : row_q + 1'b1;
        if (row_at_max) begin
          col_d = col_at_max ? '0 : col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row      = row_q;
  assign col      = col_q;
  assign last_col = col_major ? row_at_max : col_at_max;
  assign last     = row_at_max && col_at_max;

endmodule

// File: rtl/mat_stream_out.sv
// Snapshots a whole matrix on start and streams it element by element over valid/ready,
// in row-major or (transpose=1) column-major order, then pulses done for one cycle.
module mat_stream_out
  import mat_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  localparam int IW_A = idx_w(SIZE_A),
  localparam int IW_B = idx_w(SIZE_B)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_matrix [SIZE_A][SIZE_B],
  input  logic                     start,
  input  logic                     transpose,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [IW_A-1:0]          m_row,
  output logic [IW_B-1:0]          m_col,
  output logic                     m_last_col,
  output logic                     m_last
);

  mat_stream_state_t state_q;
  logic              transpose_q;
  logic signed [DATA_W-1:0] buf_q [SIZE_A][SIZE_B];

  logic            start_accept;
  logic            streaming;
  logic            xfer;
  logic [IW_A-1:0] row_idx;
  logic [IW_B-1:0] col_idx;
  logic            last_col_idx;
  logic            last_idx;

  assign start_accept = (state_q == IDLE) && start;
  assign streaming    = (state_q == STREAM);
  assign xfer         = streaming && m_ready;

  mat_index_counter #(
    .SIZE_A (SIZE_A),
    .SIZE_B (SIZE_B)
  ) u_index (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_accept),
    .advance   (xfer),
    .col_major (transpose_q),
    .row       (row_idx),
    .col       (col_idx),
    .last_col  (last_col_idx),
    .last      (last_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      transpose_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= STREAM;
            transpose_q <= transpose;
          end
        end
        STREAM: begin
          if (m_ready && last_idx) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The snapshot buffer is deliberately left out of reset so it maps onto plain registers/RAM.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE_A; gi++) begin : g_buf_row
      always_ff @(posedge clk) begin
        if (start_accept) begin
          buf_q[gi] <= in_matrix[gi];
        end
      end
    end
  endgenerate

  assign busy       = streaming;
  assign done       = (state_q == DONE);
  assign m_valid    = streaming;
  assign m_data     = streaming ? buf_q[row_idx][col_idx] : '0;
  assign m_row      = row_idx;
  assign m_col      = col_idx;
  assign m_last_col = streaming && last_col_idx;
  assign m_last     = streaming && last_idx;

endmodule

// File: doc/mat_stream_out.md
# mat_stream_out

Serialises a fully loaded matrix from the parallel file-loader stage into an element-by-element valid/ready stream, in either row-major or column-major order. It sits directly downstream of the matrix loader and feeds streaming arithmetic stages such as whitening and ICA. The whole matrix is snapshotted on `start`, so the upstream matrix may change while streaming.

## Interface
- `SIZE_A`, default 8: number of rows (≥1).
- `SIZE_B`, default 8: number of columns (≥1).
- `IW_A` (derived localparam): `max(1, $clog2(SIZE_A))`.
- `IW_B` (derived localparam): `max(1, $clog2(SIZE_B))`.
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_matrix`, in, integer [SIZE_A][SIZE_B]: source matrix, 32-bit signed elements. Sampled only on an accepted `start`.
- `start`, in, 1: request to begin a frame. Accepted only in IDLE.
- `transpose`, in, 1: captured with `start`. 0 selects row-major order, 1 selects column-major order.
- `busy`, out, 1: high in STREAM.
- `done`, out, 1: one-cycle pulse after the final transfer.
- `m_data`, out, 32 signed: current element.
- `m_valid`, out, 1: `m_data` and the index/flag outputs are valid.
- `m_ready`, in, 1: downstream accept.
- `m_row`, out, IW_A: source row index of the current element.
- `m_col`, out, IW_B: source column index of the current element.
- `m_last_col`, out, 1: last element of the output line (end of row if row-major, end of column if transposed).
- `m_last`, out, 1: last element of the frame.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE → STREAM: `start`=1 at an edge.
  - Snapshot `in_matrix` into the internal buffer.
  - Latch `transpose`.
  - Set indices to (0,0).
- STREAM:
  - `m_valid`=1 and `m_data`=buf[row][col].
  - A transfer occurs when `m_valid && m_ready` at an edge. On a transfer, advance the indices:
    - Row-major: col increments; on wrap to 0, row increments.
    - Column-major: row increments; on wrap to 0, col increments.
  - Indices wrap exactly at SIZE-1; they never reach SIZE.
- STREAM → DONE: on the transfer where `m_last`=1.
- DONE: `done`=1 and `m_valid`=0 for exactly one cycle, then IDLE.
- `start` in STREAM or DONE is ignored, with no queuing.
- `start` and `transpose` are don't-care in any state other than IDLE.
- Flag definitions:
  - `m_last_col` = (row-major ? col==SIZE_B-1 : row==SIZE_A-1).
  - `m_last` = (row==SIZE_A-1 && col==SIZE_B-1).
- Degenerate 1×1 matrix: a single beat with `m_last_col`=`m_last`=1.
- No arithmetic is performed on the data; elements pass bit-exact.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE and all outputs 0 (`busy`, `done`, `m_valid`, `m_data`, `m_row`, `m_col`, `m_last_col`, `m_last`). Buffer contents are not reset.
- Reset mid-stream: `m_valid` drops immediately and the frame is abandoned. After release, only a new `start` restarts streaming, from (0,0).
- Latency: with `start` at edge t0, `m_valid`=1 in the cycle after t0 carrying element (0,0).
- Throughput: one element per cycle while `m_ready`=1. With `m_ready` held high, `m_valid` is high for SIZE_A·SIZE_B consecutive cycles, and `done` pulses in the next cycle.
- Backpressure: while `m_valid && !m_ready`, `m_data`, `m_row`, `m_col`, `m_last_col` and `m_last` hold stable. No element is skipped or duplicated.
- `m_valid` never depends combinationally on `m_ready`.
- The earliest accepted next `start` is in the cycle after `done` (IDLE). Minimum frame period: SIZE_A·SIZE_B + 2 cycles.

## Structure
- Shared package `mat_pkg`:
  - `typedef enum logic [1:0] {IDLE, STREAM, DONE} mat_stream_state_t`.
  - A `idx_w(n)` function returning `max(1, $clog2(n))`, for reuse by other matrix stages.
- Natural sub-module: `mat_index_counter`, a two-level wrapping counter.
  - Inputs: `advance` and `col_major`.
  - Outputs: `row`, `col`, `last_col` and `last`.
  - Async reset via `rst_n`, plus a synchronous `clear`.
- Top level holds the FSM, the snapshot buffer and the output mux.

## Test plan
Bench parameters: SIZE_A=2, SIZE_B=3, in_matrix = {{1,2,3},{4,5,6}}.
- Reset: `rst_n`=0 → all outputs 0. After release with no `start`, `m_valid` stays 0.
- Row-major, `m_ready`=1:
  - `start` → data 1,2,3,4,5,6 in 6 consecutive cycles.
  - `m_last_col` on 3 and 6; `m_last` on 6.
  - `done` one cycle after 6; `busy` high for exactly 6 cycles.
- Transpose=1, `m_ready`=1 → data 1,4,2,5,3,6 with (row,col) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2). `m_last_col` on 4, 5 and 6.
- Backpressure: `m_ready`=0 for 3 cycles while element 3 is presented → `m_data`=3, `m_row`=0, `m_col`=2 held stable. Resume → 4,5,6 with no loss or duplication.
- Snapshot/ignore:
  - Change `in_matrix` to all 9 after `start` → stream is still 1..6.
  - Pulse `start` during STREAM → no restart and exactly one `done`.
- Reset mid-frame: assert `rst_n`=0 after 2 transfers → `m_valid`=0 immediately. After release and a new `start` → stream begins at 1.
